// File: rtl/mux_arb_2to1_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
package mux_arb_2to1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  // Width needed to hold beat counts 0..max_burst
  function automatic int beat_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux_2to1_w.sv
// Plain 2:1 data mux, widened to DATA_W bits; sel=1 picks in_1.
module mux_2to1_w #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  output logic [DATA_W-1:0] out
);

  assign out = sel ? in_1 : in_0;

endmodule

// File: rtl/mux_arb_2to1.sv
// Round-robin arbiter owning the select of a 2:1 mux; grants are held for
// bursts of up to MAX_BURST accepted beats, then rotated to the other side.
module mux_arb_2to1
  import mux_arb_2to1_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         req,
  input  logic [DATA_W-1:0]                  in_0,
  input  logic [DATA_W-1:0]                  in_1,
  output logic [1:0]                         gnt,
  output logic                               sel,
  output logic [DATA_W-1:0]                  out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [beat_cnt_w(MAX_BURST)-1:0]   beat_cnt
);

  localparam int CNT_W = beat_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] next_cnt;
  logic             rr_ptr;
  logic             next_rr;
  logic             next_sel;
  logic             beat;
  logic             cur;
  logic             other;
  logic             burst_end;

  always_comb begin
    case (state)
      ST_GNT0: gnt = 2'b01;
      ST_GNT1: gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign out_valid = gnt[sel] & req[sel];
  assign beat      = out_valid & out_ready;
  assign cur       = (state == ST_GNT1);
  assign other     = ~cur;

  // A burst ends on its last accepted beat or when the owner drops req;
  // the other side takes over directly if it is waiting.
  always_comb begin
    next_state = state;
    next_cnt   = beat_cnt;
    next_rr    = rr_ptr;
    next_sel   = sel;
    burst_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req[0] && (!req[1] || !rr_ptr)) begin
          next_state = ST_GNT0;
          next_sel   = 1'b0;
        end else if (req[1]) begin
          next_state = ST_GNT1;
          next_sel   = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        burst_end = (beat && (beat_cnt == LAST_BEAT)) || !req[cur];
        if (burst_end) begin
          next_rr  = other;
          next_cnt = '0;
          if (req[other]) begin
            next_state = other ? ST_GNT1 : ST_GNT0;
            next_sel   = other;
          end else if (!req[cur]) begin
            next_state = ST_IDLE;
          end
        end else begin
          next_cnt = beat_cnt + CNT_W'(beat);
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      rr_ptr   <= 1'b0;
      sel      <= 1'b0;
    end else begin
      state    <= next_state;
      beat_cnt <= next_cnt;
      rr_ptr   <= next_rr;
      sel      <= next_sel;
    end
  end

  mux_2to1_w #(.DATA_W(DATA_W)) u_mux (
    .sel  (sel),
    .in_0 (in_0),
    .in_1 (in_1),
    .out  (out_data)
  );

endmodule

// File: doc/mux_arb_2to1.md
Name: mux_arb_2to1

Overview:
Two-requester round-robin arbiter that owns the select line of a 2:1 data mux and shares one downstream output between requesters 0 and 1. Grants are held for bursts of up to MAX_BURST accepted beats, then rotated fairly. Output uses a valid/ready handshake. The block sits between two data sources and a single consumer.

Parameters:
DATA_W, 8, width of each input data word and of out_data
MAX_BURST, 4, max accepted beats per grant before forced rotation (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  2  req[i]=1: requester i has a valid word on in_i
in_0  input  DATA_W  requester 0 data
in_1  input  DATA_W  requester 1 data
gnt  output  2  one-hot grant, registered; 00 when idle
sel  output  1  mux select, registered; 1 = requester 1
out_data  output  DATA_W  sel ? in_1 : in_0, combinational from registered sel
out_valid  output  1  gnt[sel] & req[sel]
out_ready  input  1  downstream accepts beat
beat_cnt  output  $clog2(MAX_BURST+1)  accepted beats in current grant

Behaviour:
- One clock; reset is asynchronous and active-low. Asserting rst_n=0 immediately forces: state IDLE, gnt=00, sel=0, beat_cnt=0, rr_ptr=0 (requester 0 wins the first tie). out_valid=0 follows combinationally. Reset mid-burst discards the grant; no beat completes in that cycle.
- Accept: beat = out_valid & out_ready. A requester holds req and data stable while granted and not accepted.
- States: IDLE, GNT0, GNT1 (gnt/sel decoded from registered state).
- IDLE: req=01 -> GNT0; req=10 -> GNT1; req=11 -> GNT[rr_ptr]; req=00 -> stay. Arbitration latency is 1 cycle, from req sampled high to gnt high.
- GNTi, grant end on edge where either (a) beat and beat_cnt==MAX_BURST-1, or (b) req[i]=0.
- No end: beat_cnt += beat.
- On end: rr_ptr <= other; beat_cnt <= 0. If req[other]=1 -> GNTother (no idle bubble). Else if req[i]=1 (case a) -> stay GNTi with fresh burst. Else -> IDLE.
- Simultaneous req[i] drop and req[other] rise: handled as case (b), so the grant moves directly to other.
- beat_cnt never reaches MAX_BURST and resets on every grant change.
- MAX_BURST=1 gives strict per-beat alternation under contention.
- gnt is always one-hot or zero. sel holds its last value in IDLE.
- out_ready low stalls the burst indefinitely. There is no timeout.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2) and the beat-count width function.
- One natural sub-module: the existing mux_2to1 datapath, instantiated for out_data, widened to DATA_W (mux_2to1_w).
- FSM, counter and rr_ptr live in the top.

Test Plan:
- Reset: rst_n=0 mid-burst at arbitrary phase -> gnt=00, sel=0, out_valid=0, beat_cnt=0 without a clock edge.
- Single requester: req=01, in_0=0xA5, out_ready=1 -> gnt=01 one cycle later, out_data=0xA5. After 4 beats, beat_cnt wraps to 0 and the grant is held (no rival).
- Contention: req=11 from reset, ready=1, in_0=0x11, in_1=0x22 -> 4 beats of 0x11, then 4 beats of 0x22, alternating with no idle cycle between bursts.
- Backpressure: GNT1, out_ready=0 for 5 cycles with req=11 -> grant stays 10, beat_cnt frozen, out_data stable 0x22; resumes on ready=1.
- Early release: GNT0 after 2 beats, req0 drops while req1=1 -> next edge gnt=10, beat_cnt=0, rr_ptr=1. If req1=0 instead -> IDLE, gnt=00.
- Tie after idle: after GNT0 ends to IDLE, then req=11 -> GNT1 granted (rr_ptr=1).
